// File: rtl/fir_mac_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fir_mac_engine: sequential one-MAC-per-cycle FIR with circular delay line |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module fir_mac_engine #(
  parameter int N_TAPS = 32,
  parameter int DATA_W = 16,
  parameter int COEF_W = 16
) (
  input  logic                      in_clk,
  input  logic                      rst,
  input  logic                      sample_stb,
  input  logic [DATA_W-1:0]         din,
  input  logic                      coef_we,
  input  logic [$clog2(N_TAPS)-1:0] coef_addr,
  input  logic [COEF_W-1:0]         coef_din,
  output logic [DATA_W-1:0]         dout,
  output logic                      dout_valid,
  output logic                      busy,
  output logic                      overrun
);

  localparam int c_ptr_w  = $clog2(N_TAPS);
  localparam int c_prod_w = DATA_W + COEF_W;
  localparam int c_acc_w  = DATA_W + COEF_W + c_ptr_w;

  localparam logic [c_ptr_w-1:0]         c_one    = c_ptr_w'(1);
  localparam logic [c_ptr_w-1:0]         c_k_last = c_ptr_w'(N_TAPS - 1);
  localparam logic signed [c_acc_w-1:0]  c_round  = c_acc_w'(1) << (COEF_W - 2);
  localparam logic signed [c_acc_w-1:0]  c_y_max  = {{(c_acc_w-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [c_acc_w-1:0]  c_y_min  = {{(c_acc_w-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0]          c_dout_max = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0]          c_dout_min = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic signed [DATA_W-1:0]  r_x    [N_TAPS];
  logic signed [COEF_W-1:0]  r_coef [N_TAPS];
  logic signed [c_acc_w-1:0] r_acc;
  logic [c_ptr_w-1:0]        r_k;
  logic [c_ptr_w-1:0]        r_wr_ptr;
  logic [DATA_W-1:0]         r_dout;
  logic                      r_dout_valid;
  logic                      r_overrun;

  logic [c_ptr_w-1:0]        w_rd_ptr;
  logic signed [c_prod_w-1:0] w_prod;
  logic signed [c_acc_w-1:0] w_prod_ext;
  logic signed [c_acc_w-1:0] w_sum;
  logic signed [c_acc_w-1:0] w_shift;
  logic [DATA_W-1:0]         w_y;

  // Tap k reads k samples back from the newest one; wraps naturally at c_ptr_w bits.
  assign w_rd_ptr   = r_wr_ptr - r_k;
  assign w_prod     = r_x[w_rd_ptr] * r_coef[r_k];
  assign w_prod_ext = {{(c_acc_w-c_prod_w){w_prod[c_prod_w-1]}}, w_prod};

  assign w_sum   = r_acc + c_round;
  assign w_shift = w_sum >>> (COEF_W - 1);

  always_comb begin
    w_y = w_shift[DATA_W-1:0];
    if (w_shift > c_y_max) begin
      w_y = c_dout_max;
    end else if (w_shift < c_y_min) begin
      w_y = c_dout_min;
    end
  end

  always_ff @(posedge in_clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (sample_stb) w_state_nxt = S_MAC;
      S_MAC:   if (r_k == c_k_last) w_state_nxt = S_OUT;
      S_OUT:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge in_clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_TAPS; i++) begin
        r_x[i]    <= '0;
        r_coef[i] <= '0;
      end
      r_acc        <= '0;
      r_k          <= '0;
      r_wr_ptr     <= '0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_dout_valid <= 1'b0;
      if (sample_stb && (r_state != S_IDLE)) begin
        r_overrun <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          // A write coinciding with a strobe lands before the first MAC edge.
          if (coef_we) begin
            r_coef[coef_addr] <= coef_din;
          end
          if (sample_stb) begin
            r_x[r_wr_ptr] <= din;
            r_acc         <= '0;
            r_k           <= '0;
          end
        end
        S_MAC: begin
          r_acc <= r_acc + w_prod_ext;
          r_k   <= r_k + c_one;
          if (r_k == c_k_last) begin
            r_wr_ptr <= r_wr_ptr + c_one;
          end
        end
        S_OUT: begin
          r_dout       <= w_y;
          r_dout_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign busy       = (r_state != S_IDLE);
  assign overrun    = r_overrun;

endmodule
`default_nettype wire

// File: doc/fir_mac_engine.md
# fir_mac_engine

Sequential multiply-accumulate FIR core for the lowpass filter path. It sits directly downstream of the sample-rate clock divider: each one-cycle sample strobe captures one input sample into a circular delay line. It then computes one filtered output by iterating over all taps, one multiply-accumulate per in_clk cycle. Coefficients are loaded at run time through a simple write port.

## Interface
- N_TAPS, 32, number of filter taps; power of two, ≥ 2
- DATA_W, 16, signed sample width (input and output)
- COEF_W, 16, signed coefficient width, Q1.(COEF_W-1) format
- in_clk  input  1  system clock; all logic on rising edge
- rst  input  1  reset, asynchronous, active-low
- sample_stb  input  1  one-cycle sample strobe (clock-divider output)
- din  input  DATA_W  signed input sample, valid when sample_stb=1
- coef_we  input  1  coefficient write enable
- coef_addr  input  $clog2(N_TAPS)  coefficient index k
- coef_din  input  COEF_W  signed coefficient value
- dout  output  DATA_W  signed filtered sample; held until next result
- dout_valid  output  1  one-cycle pulse when dout updates
- busy  output  1  high while a computation is in progress
- overrun  output  1  sticky; strobe arrived while busy

## Operation
- Storage:
  - Delay line x[0..N_TAPS-1] of DATA_W bits, with write pointer wr_ptr.
  - Coefficient array c[0..N_TAPS-1] of COEF_W bits.
  - Accumulator acc of ACC_W = DATA_W+COEF_W+$clog2(N_TAPS) bits, signed.
- State machine IDLE → MAC → OUT → IDLE.
- IDLE, sample_stb=1 at an edge:
  - x[wr_ptr] <= din; acc <= 0; k <= 0; busy <= 1; go to MAC.
  - Pointer for the tap-0 read is the newly written slot.
- MAC: each edge adds c[k] * x[(wr_ptr - k) mod N_TAPS] to acc (full-precision signed product) and increments k.
  - After the edge with k = N_TAPS-1: wr_ptr <= wr_ptr+1 (wraps modulo N_TAPS); go to OUT.
- OUT, single edge:
  - Rounding: y = (acc + 2^(COEF_W-2)) >>> (COEF_W-1), arithmetic shift, round half up.
  - Saturation: y is clamped to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - dout <= y; dout_valid <= 1; busy <= 0; go to IDLE.
- dout_valid is 1 for exactly one cycle. dout holds its value between results.
- Strobe while busy (MAC or OUT): the sample is discarded and overrun <= 1. The computation in progress is unaffected. overrun clears only on reset.
- Coefficient writes:
  - coef_we in IDLE: c[coef_addr] <= coef_din.
  - coef_we while busy: ignored.
  - coef_we and sample_stb in the same IDLE cycle: both take effect; the new coefficient is used by this computation.
- Reset (rst low, any time, including mid-MAC):
  - Aborts the computation; no dout_valid is produced.
  - State ← IDLE; x[], c[], acc, k, wr_ptr ← 0.
  - dout ← 0; dout_valid, busy, overrun ← 0.

## Timing
- Strobe captured at edge E0.
- MAC adds occur at edges E1..E_N_TAPS.
- OUT at edge E_(N_TAPS+1): dout and dout_valid are high in the cycle following it. Latency is N_TAPS+1 edges from the capture edge.
- busy is high from after E0 until after E_(N_TAPS+1), i.e. for N_TAPS+1 cycles.
- A new strobe is accepted at E_(N_TAPS+2) or later. The upstream divider ratio must therefore satisfy C ≥ N_TAPS+2.
- A strobe at exactly E_(N_TAPS+1) (the OUT edge) counts as an overrun.
- Read path from the delay line and coefficients is combinational within the MAC cycle. There is no extra pipeline stage.

## Test plan
- Reset: hold rst low, then release → dout=0, dout_valid=0, busy=0, overrun=0. The first strobe after release with all coefficients at zero → dout=0.
- Pass-through (N_TAPS=32):
  - Stimulus: c[0]=0x4000, all others 0; strobe with din=1000.
  - Response: dout=500, with dout_valid high exactly 33 edges after the capture edge; busy high for 33 cycles.
- Impulse response (C=40):
  - Stimulus: c[k]=(k+1)*256; din=16384, then 31 strobes with din=0.
  - Response: the j-th output (j=0..31) is (j+1)*128. The 33rd output is 0, confirming wr_ptr wrap.
- Saturation:
  - Stimulus: all c[k]=32767; 32 strobes with din=32767.
  - Response: final dout=32767.
  - Then 32 strobes with din=-32768 → final dout=-32768.
- Overrun:
  - Stimulus: strobe at E0 and a second strobe at E5.
  - Response: only one dout_valid, at E33; overrun=1 and stays 1.
  - A coefficient write issued at E10 is ignored, verified by readback via a subsequent impulse.
- Reset mid-MAC:
  - Stimulus: rst low at E10 of a computation.
  - Response: no dout_valid; all outputs 0. The delay line and coefficients are cleared, so after reloading c[0]=0x4000, din=1000 gives dout=500.
